// File: rtl/fmul32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fmul32_pkg
//  Purpose  : Shared types and constants for the FMUL32 back-end stage:
//             FSM state encoding, IEEE-754 single-precision field widths,
//             exponent bias and the canonical quiet NaN.
//  Revision : 1.0 - initial release
// ============================================================================
package fmul32_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    SPEC  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BIAS       = 127;
  localparam int EXP_MAX    = 2 * BIAS + 1;   // 255: all-ones biased exponent
  localparam int EXP_FLD_W  = 8;              // packed exponent field width
  localparam int IN_EXP_W   = 10;             // signed exponent from stage 1
  // One guard bit above the input exponent so +1 (normalize) and +1
  // (rounding carry) can never wrap, even for extreme stage-1 inputs.
  localparam int CALC_EXP_W = IN_EXP_W + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage
`default_nettype wire

// File: rtl/fmul32_round.sv
`default_nettype none
// ============================================================================
//  Module   : fmul32_round
//  Purpose  : Combinational normalize + round-to-nearest-even + pack for the
//             48-bit significand product of two normal single-precision
//             operands. Overflow saturates to Inf; results below the normal
//             range flush to signed zero (no subnormal output).
//  Ports    : prod_i   - full significand product {1,fa} x {1,fb}
//             exp_i    - signed unbiased-sum exponent EA+EB-127
//             sign_i   - result sign
//             result_o - packed IEEE-754 word
//  Revision : 1.0 - initial release
// ============================================================================
module fmul32_round
  import fmul32_pkg::*;
#(
  parameter int MANT_W = 23
) (
  input  logic [2*MANT_W+1:0]         prod_i,
  input  logic signed [IN_EXP_W-1:0]  exp_i,
  input  logic                        sign_i,
  output logic [MANT_W+EXP_FLD_W:0]   result_o
);

  localparam int PROD_W = 2 * MANT_W + 2;
  localparam logic signed [CALC_EXP_W-1:0] c_EXP_MAX  = CALC_EXP_W'(EXP_MAX);
  localparam logic signed [CALC_EXP_W-1:0] c_EXP_ZERO = '0;

  logic signed [CALC_EXP_W-1:0] w_exp_ext;
  logic signed [CALC_EXP_W-1:0] w_exp_norm;
  logic signed [CALC_EXP_W-1:0] w_exp_fin;
  logic [MANT_W-1:0]            w_frac;
  logic [MANT_W-1:0]            w_frac_fin;
  logic [MANT_W:0]              w_frac_sum;
  logic                         w_guard;
  logic                         w_sticky;
  logic                         w_inc;

  assign w_exp_ext = {exp_i[IN_EXP_W-1], exp_i};

  // Product of two [1,2) significands lies in [1,4): the top bit decides
  // whether the binary point moves one place left.
  always_comb begin
    if (prod_i[PROD_W-1]) begin
      w_exp_norm = w_exp_ext + CALC_EXP_W'(1);
      w_frac     = prod_i[PROD_W-2 -: MANT_W];
      w_guard    = prod_i[PROD_W-2-MANT_W];
      w_sticky   = |prod_i[PROD_W-3-MANT_W:0];
    end else begin
      w_exp_norm = w_exp_ext;
      w_frac     = prod_i[PROD_W-3 -: MANT_W];
      w_guard    = prod_i[PROD_W-3-MANT_W];
      w_sticky   = |prod_i[PROD_W-4-MANT_W:0];
    end
  end

  assign w_inc      = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_sum = {1'b0, w_frac} + {{MANT_W{1'b0}}, w_inc};
  // A carry out of the fraction leaves it all-zero, i.e. significand 1.0
  // at the next exponent.
  assign w_frac_fin = w_frac_sum[MANT_W-1:0];
  assign w_exp_fin  = w_exp_norm + {{(CALC_EXP_W-1){1'b0}}, w_frac_sum[MANT_W]};

  always_comb begin
    if (w_exp_fin >= c_EXP_MAX) begin
      result_o = {sign_i, {EXP_FLD_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (w_exp_fin <= c_EXP_ZERO) begin
      result_o = {sign_i, {(EXP_FLD_W+MANT_W){1'b0}}};
    end else begin
      result_o = {sign_i, w_exp_fin[EXP_FLD_W-1:0], w_frac_fin};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fmul32_mant_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fmul32_mant_stage
//  Purpose  : Back-end stage of the FMUL32 pipeline. Accepts the stage-1
//             bundle, multiplies the significands with an iterative
//             radix-2^BITS_PER_CYC shift-add, then rounds/packs. NaN, Inf,
//             zero and invalid operations bypass the multiplier. One
//             operation in flight; valid/ready on both sides.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready, in_sign, in_res_val, in_nan, in_inf,
//             in_zero, in_exp (signed), in_frac_a, in_frac_b
//             out_valid/out_ready, result (IEEE-754), val
//  Revision : 1.0 - initial release
// ============================================================================
module fmul32_mant_stage
  import fmul32_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int MANT_W       = 23,
  parameter int BITS_PER_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic                       in_res_val,
  input  logic                       in_nan,
  input  logic                       in_inf,
  input  logic                       in_zero,
  input  logic signed [IN_EXP_W-1:0] in_exp,
  input  logic [MANT_W-1:0]          in_frac_a,
  input  logic [MANT_W-1:0]          in_frac_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          result,
  output logic                       val
);

  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int ITERS  = SIG_W / BITS_PER_CYC;
  localparam int CNT_W  = $clog2(ITERS + 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PROD_W-1:0]           mcand_q, mcand_d;
  logic [SIG_W-1:0]            mplier_q, mplier_d;
  logic [PROD_W-1:0]           acc_q, acc_d;
  logic                        sign_q, sign_d;
  logic                        res_val_q, res_val_d;
  logic                        nan_q, nan_d;
  logic                        inf_q, inf_d;
  logic                        zero_q, zero_d;
  logic signed [IN_EXP_W-1:0]  exp_q, exp_d;
  logic [DATA_W-1:0]           result_q, result_d;
  logic                        val_q, val_d;

  logic [PROD_W-1:0]           w_pp;
  logic [DATA_W-1:0]           w_round_res;

  // Partial product for the current multiplier digit (LSB-first scan).
  assign w_pp = mcand_q * PROD_W'(mplier_q[BITS_PER_CYC-1:0]);

  fmul32_round #(
    .MANT_W (MANT_W)
  ) u_round (
    .prod_i   (acc_q),
    .exp_i    (exp_q),
    .sign_i   (sign_q),
    .result_o (w_round_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      res_val_q <= 1'b0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      result_q  <= '0;
      val_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      sign_q    <= sign_d;
      res_val_q <= res_val_d;
      nan_q     <= nan_d;
      inf_q     <= inf_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      result_q  <= result_d;
      val_q     <= val_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    res_val_d = res_val_q;
    nan_d     = nan_q;
    inf_d     = inf_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    result_d  = result_q;
    val_d     = val_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = in_sign;
          res_val_d = in_res_val;
          nan_d     = in_nan;
          inf_d     = in_inf;
          zero_d    = in_zero;
          exp_d     = in_exp;
          mcand_d   = {{SIG_W{1'b0}}, 1'b1, in_frac_a};
          mplier_d  = {1'b1, in_frac_b};
          acc_d     = '0;
          cnt_d     = '0;
          if (!in_res_val || in_nan || in_inf || in_zero) begin
            state_d = SPEC;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d    = acc_q + w_pp;
        mcand_d  = mcand_q << BITS_PER_CYC;
        mplier_d = mplier_q >> BITS_PER_CYC;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d = w_round_res;
        val_d    = res_val_q;
        state_d  = DONE;
      end
      SPEC: begin
        val_d = res_val_q;
        if (!res_val_q) begin
          result_d = '0;
        end else if (nan_q) begin
          result_d = DATA_W'(QNAN);
        end else if (inf_q) begin
          result_d = {sign_q, {EXP_FLD_W{1'b1}}, {MANT_W{1'b0}}};
        end else begin
          result_d = {sign_q, {(DATA_W-1){1'b0}}};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign val       = val_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul32_mant_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fmul32_mant_stage
//  Purpose  : Self-checking bench for fmul32_mant_stage: directed corner
//             cases, back-pressure, mid-operation reset and randomized
//             operations against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fmul32_mant_stage;

  localparam int ITERS = 12;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic              in_res_val;
  logic              in_nan;
  logic              in_inf;
  logic              in_zero;
  logic signed [9:0] in_exp;
  logic [22:0]       in_frac_a;
  logic [22:0]       in_frac_b;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              val;

  int checks   = 0;
  int failures = 0;

  fmul32_mant_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_res_val (in_res_val),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .in_exp     (in_exp),
    .in_frac_a  (in_frac_a),
    .in_frac_b  (in_frac_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .val        (val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact integer product, split into kept significand and
  // remainder, round half to even by comparing the remainder to one half.
  function automatic logic [32:0] model(input bit sg, input bit rv, input bit nan,
                                        input bit inf, input bit zero, input int e,
                                        input logic [22:0] fa, input logic [22:0] fb);
    logic [63:0] sa, sb, p, q, rem, half;
    int sh, ee;
    if (!rv)  return {1'b0, 32'h0};
    if (nan)  return {1'b1, 32'h7FC0_0000};
    if (inf)  return {1'b1, sg, 8'hFF, 23'h0};
    if (zero) return {1'b1, sg, 31'h0};
    sa = 64'(fa) + 64'h80_0000;
    sb = 64'(fb) + 64'h80_0000;
    p  = sa * sb;
    ee = e;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      ee = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ee = ee + 1;
    end
    if (ee >= 255) return {1'b1, sg, 8'hFF, 23'h0};
    if (ee <= 0)   return {1'b1, sg, 31'h0};
    return {1'b1, sg, 8'(ee), q[22:0]};
  endfunction

  // Issues one bundle, checks latency/result/val, optionally stalls the
  // output (driving an extra bundle that must be ignored), then handshakes.
  // Entered and left #1 after a rising edge.
  task automatic run_op(input string tag, input bit sg, input bit rv, input bit nan,
                        input bit inf, input bit zero, input int e,
                        input logic [22:0] fa, input logic [22:0] fb,
                        input logic [31:0] exp_res, input bit exp_val, input int stall);
    int n, lat, exp_lat;
    exp_lat    = (!rv || nan || inf || zero) ? 2 : ITERS + 2;
    in_sign    = sg;
    in_res_val = rv;
    in_nan     = nan;
    in_inf     = inf;
    in_zero    = zero;
    in_exp     = 10'(e);
    in_frac_a  = fa;
    in_frac_b  = fb;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check({tag, "_accept"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat + 1), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_val"}, 32'(val), 32'(exp_val));
    if (stall > 0) begin
      in_valid   = 1'b1;
      in_nan     = 1'b1;
      in_res_val = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_res"}, result, exp_res);
      check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ir"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [32:0] m;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_res_val = 1'b0;
    in_nan     = 1'b0;
    in_inf     = 1'b0;
    in_zero    = 1'b0;
    in_exp     = '0;
    in_frac_a  = '0;
    in_frac_b  = '0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_val", 32'(val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op("d_1p5x2",   0, 1, 0, 0, 0, 128, 23'h40_0000, 23'h00_0000, 32'h4040_0000, 1, 0);
    run_op("d_tie_odd", 0, 1, 0, 0, 0, 127, 23'h40_0000, 23'h00_0001, 32'h3FC0_0002, 1, 0);
    run_op("d_ulp_sq",  0, 1, 0, 0, 0, 127, 23'h00_0001, 23'h00_0001, 32'h3F80_0002, 1, 0);
    run_op("d_ovf",     0, 1, 0, 0, 0, 254, 23'h7F_FFFF, 23'h7F_FFFF, 32'h7F80_0000, 1, 0);
    run_op("d_ovf_neg", 1, 1, 0, 0, 0, 254, 23'h7F_FFFF, 23'h7F_FFFF, 32'hFF80_0000, 1, 0);
    run_op("d_unf",     0, 1, 0, 0, 0, -5,  23'h00_0000, 23'h00_0000, 32'h0000_0000, 1, 0);
    run_op("d_unf_neg", 1, 1, 0, 0, 0, -5,  23'h00_0000, 23'h00_0000, 32'h8000_0000, 1, 0);
    run_op("d_nan",     1, 1, 1, 1, 0, 100, 23'h12_3456, 23'h65_4321, 32'h7FC0_0000, 1, 0);
    run_op("d_inf_neg", 1, 1, 0, 1, 0, 100, 23'h00_0000, 23'h00_0000, 32'hFF80_0000, 1, 0);
    run_op("d_zero",    1, 1, 0, 0, 1, 100, 23'h00_0000, 23'h00_0000, 32'h8000_0000, 1, 0);
    run_op("d_invalid", 1, 0, 1, 0, 0, 100, 23'h00_0000, 23'h00_0000, 32'h0000_0000, 0, 0);
    run_op("d_stall",   0, 1, 0, 0, 0, 128, 23'h40_0000, 23'h00_0000, 32'h4040_0000, 1, 5);

    // Reset in the middle of the iterative multiply.
    in_sign    = 1'b0;
    in_res_val = 1'b1;
    in_nan     = 1'b0;
    in_inf     = 1'b0;
    in_zero    = 1'b0;
    in_exp     = 10'sd130;
    in_frac_a  = 23'h55_5555;
    in_frac_b  = 23'h2A_AAAA;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_result", result, 32'h0);
    check("mrst_val", 32'(val), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("d_after_rst", 0, 1, 0, 0, 0, 128, 23'h40_0000, 23'h00_0000, 32'h4040_0000, 1, 0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 60; k++) begin
      int  r, e, st;
      bit  sg, rv, fn, fi, fz;
      logic [22:0] fa, fb;
      r  = int'($urandom_range(0, 9));
      sg = 1'($urandom);
      rv = 1'b1;
      fn = 1'b0;
      fi = 1'b0;
      fz = 1'b0;
      if (r < 4) begin
        fn = 1'($urandom);
        fi = 1'($urandom);
        fz = 1'($urandom);
        rv = (r != 3);
      end
      e  = int'($urandom_range(0, 320)) - 20;
      fa = 23'($urandom);
      fb = 23'($urandom);
      if (r == 4) fa = 23'h7F_FFFF;
      st = int'($urandom_range(0, 2));
      m  = model(sg, rv, fn, fi, fz, e, fa, fb);
      run_op("rnd", sg, rv, fn, fi, fz, e, fa, fb, m[31:0], m[32], st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
